// File: rtl/sw_ctrl_if.sv
// Control/command bundle between the stopwatch divider, user controls and the
// mode controller. The slave side is the controller, the master side drives it.
interface sw_ctrl_if;
    localparam int unsigned STATE_W = 2;

    logic               tick_1hz;
    logic               tick_2hz;
    logic               tick_blink;
    logic               pause_btn;
    logic               adj;
    logic               sel;

    logic               cnt_en;
    logic               sec_inc;
    logic               min_inc;
    logic               cnt_clr;
    logic               div_sync;
    logic               blank_min;
    logic               blank_sec;
    logic               running;
    logic [STATE_W-1:0] state_o;

    modport slave (
        input  tick_1hz, tick_2hz, tick_blink, pause_btn, adj, sel,
        output cnt_en, sec_inc, min_inc, cnt_clr, div_sync,
               blank_min, blank_sec, running, state_o
    );

    modport master (
        output tick_1hz, tick_2hz, tick_blink, pause_btn, adj, sel,
        input  cnt_en, sec_inc, min_inc, cnt_clr, div_sync,
               blank_min, blank_sec, running, state_o
    );
endinterface

// File: rtl/sw_ctrl.sv
// Stopwatch mode controller: Run / Paused / Adjust FSM turning divider ticks and
// user controls into one-cycle counter commands and display blanking masks.
module sw_ctrl (
    input  logic        clk,
    input  logic        RESET,
    sw_ctrl_if.slave    bus
);
    localparam int unsigned STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_PAUSED = 2'b00,
        ST_RUN    = 2'b01,
        ST_ADJ    = 2'b10
    } state_t;

    state_t state_q, state_d;

    logic run_saved_q, run_saved_d;
    logic blink_ph_q,  blink_ph_d;
    logic pause_prev_q;
    logic sel_prev_q;

    logic cnt_en_q,    cnt_en_d;
    logic sec_inc_q,   sec_inc_d;
    logic min_inc_q,   min_inc_d;
    logic cnt_clr_q;
    logic div_sync_q,  div_sync_d;
    logic blank_min_q, blank_min_d;
    logic blank_sec_q, blank_sec_d;
    logic running_q,   running_d;

    logic pause_edge;
    assign pause_edge = bus.pause_btn & ~pause_prev_q;

    // State and registered outputs; pause_prev resets high so a held button cannot toggle
    always_ff @(posedge clk) begin
        if (RESET) begin
            state_q      <= ST_PAUSED;
            run_saved_q  <= 1'b0;
            blink_ph_q   <= 1'b0;
            pause_prev_q <= 1'b1;
            sel_prev_q   <= bus.sel;
            cnt_en_q     <= 1'b0;
            sec_inc_q    <= 1'b0;
            min_inc_q    <= 1'b0;
            cnt_clr_q    <= 1'b1;
            div_sync_q   <= 1'b1;
            blank_min_q  <= 1'b0;
            blank_sec_q  <= 1'b0;
            running_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            run_saved_q  <= run_saved_d;
            blink_ph_q   <= blink_ph_d;
            pause_prev_q <= bus.pause_btn;
            sel_prev_q   <= bus.sel;
            cnt_en_q     <= cnt_en_d;
            sec_inc_q    <= sec_inc_d;
            min_inc_q    <= min_inc_d;
            cnt_clr_q    <= 1'b0;
            div_sync_q   <= div_sync_d;
            blank_min_q  <= blank_min_d;
            blank_sec_q  <= blank_sec_d;
            running_q    <= running_d;
        end
    end

    // Next state: adj dominates pause edges, pause edges dominate ticks
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_PAUSED: begin
                if (bus.adj)         state_d = ST_ADJ;
                else if (pause_edge) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (bus.adj)         state_d = ST_ADJ;
                else if (pause_edge) state_d = ST_PAUSED;
            end
            ST_ADJ: begin
                if (!bus.adj)        state_d = run_saved_q ? ST_RUN : ST_PAUSED;
            end
            default:                 state_d = ST_PAUSED;
        endcase
    end

    // Command pulses, saved run flag and blink phase for the coming cycle
    always_comb begin
        cnt_en_d    = 1'b0;
        sec_inc_d   = 1'b0;
        min_inc_d   = 1'b0;
        div_sync_d  = 1'b0;
        run_saved_d = run_saved_q;
        blink_ph_d  = blink_ph_q;
        case (state_q)
            ST_PAUSED: begin
                if (bus.adj) begin
                    run_saved_d = 1'b0;
                    blink_ph_d  = 1'b0;
                end else if (pause_edge) begin
                    div_sync_d  = 1'b1;
                end
            end
            ST_RUN: begin
                if (bus.adj) begin
                    run_saved_d = 1'b1;
                    blink_ph_d  = 1'b0;
                end else if (!pause_edge && bus.tick_1hz) begin
                    cnt_en_d    = 1'b1;
                end
            end
            ST_ADJ: begin
                if (!bus.adj) begin
                    blink_ph_d = 1'b0;
                    div_sync_d = run_saved_q;
                end else begin
                    sec_inc_d = bus.tick_2hz & bus.sel;
                    min_inc_d = bus.tick_2hz & ~bus.sel;
                    if (bus.sel != sel_prev_q) blink_ph_d = 1'b0;
                    else if (bus.tick_blink)   blink_ph_d = ~blink_ph_q;
                end
            end
            default: blink_ph_d = 1'b0;
        endcase
        blank_sec_d = (state_d == ST_ADJ) & blink_ph_d & bus.sel;
        blank_min_d = (state_d == ST_ADJ) & blink_ph_d & ~bus.sel;
        running_d   = (state_d == ST_RUN);
    end

    assign bus.cnt_en    = cnt_en_q;
    assign bus.sec_inc   = sec_inc_q;
    assign bus.min_inc   = min_inc_q;
    assign bus.cnt_clr   = cnt_clr_q;
    assign bus.div_sync  = div_sync_q;
    assign bus.blank_min = blank_min_q;
    assign bus.blank_sec = blank_sec_q;
    assign bus.running   = running_q;
    assign bus.state_o   = state_q;
endmodule

// File: doc/sw_ctrl.md
# sw_ctrl

Mode controller for the stopwatch MM:SS counter datapath. It turns the divider's 1 Hz / 2 Hz / blink enables and the user controls (PAUSE button, ADJ and SEL switches) into single-cycle increment, clear and divider-resync commands for the counter, plus blanking masks for the display. It runs as a Run / Paused / Adjust state machine, so the counter itself contains no mode logic.

## Interface
Parameters: none.

Ports:
- clk  in  1  system clock; all logic on posedge.
- RESET  in  1  synchronous, active-high reset.
- tick_1hz  in  1  one-cycle enable from divider, 1 Hz.
- tick_2hz  in  1  one-cycle enable from divider, 2 Hz.
- tick_blink  in  1  one-cycle enable from divider, blink rate.
- pause_btn  in  1  debounced PAUSE level; a rising edge toggles run/pause.
- adj  in  1  level; 1 = adjust mode.
- sel  in  1  level; 0 = minutes, 1 = seconds (adjust target).
- cnt_en  out  1  pulse: increment MM:SS with full carry (59:59 wraps to 00:00).
- sec_inc  out  1  pulse: increment the seconds field only, 59→00, no carry.
- min_inc  out  1  pulse: increment the minutes field only, 59→00.
- cnt_clr  out  1  clear all four digits.
- div_sync  out  1  restart divider phase.
- blank_min  out  1  blank the minutes digits.
- blank_sec  out  1  blank the seconds digits.
- running  out  1  1 in RUN.
- state_o  out  2  00 PAUSED, 01 RUN, 10 ADJ.

## Operation
- All outputs are registered. Internal state: FSM, run_saved, pause_prev, blink_ph, sel_prev.
- Pause edge: pause_btn=1 && pause_prev=0. pause_prev updates every cycle, including in ADJ.
- **While RESET is high:**
  - Outputs: state=PAUSED, cnt_clr=1, div_sync=1, all other outputs 0.
  - Internal: run_saved=0, blink_ph=0, pause_prev=1, so a button held through reset does not toggle.
- **PAUSED:**
  - Pause edge → RUN, with a div_sync pulse.
  - Ticks are ignored.
- **RUN:**
  - tick_1hz → cnt_en pulse.
  - Pause edge → PAUSED. The pause edge has priority over a coincident tick, so no cnt_en is issued.
- **adj=1 from PAUSED or RUN:**
  - Enter ADJ; run_saved = (state==RUN); blink_ph=0.
  - adj has priority over a coincident pause edge or tick.
- **ADJ:**
  - tick_2hz → sec_inc if sel=1, else min_inc. sel is sampled at the same edge.
  - tick_1hz and pause edges are ignored.
  - tick_blink toggles blink_ph.
  - A sel change (sel≠sel_prev) forces blink_ph=0 and takes priority over tick_blink.
  - blank_sec = blink_ph & sel; blank_min = blink_ph & ~sel.
- **adj=0 in ADJ:**
  - Return to RUN if run_saved, else PAUSED.
  - A return to RUN pulses div_sync.
  - blink_ph=0 and blanks clear.
  - A tick at the exit edge is dropped.
- Outside ADJ, blank_min and blank_sec are 0.
- At most one of cnt_en, sec_inc, min_inc is high in any cycle. None is high while cnt_clr is high.

## Timing
- Input sampled at edge k → response visible after edge k, i.e. one-cycle latency. Pulses last exactly one cycle.
- cnt_clr: high for every cycle following an edge where RESET=1; low one cycle after RESET falls.
- Resume from PAUSED at edge k:
  - div_sync and running go high after edge k.
  - The first cnt_en follows the first tick_1hz after the divider restarts, i.e. no partial second.
- ADJ exit to RUN at edge k: the same div_sync behaviour applies.
- Sustained ticks at the 1 Hz input produce one cnt_en each, with no loss. Ticks are never queued: a tick in a non-matching state is discarded.

## Test plan
- **Reset and start:**
  - Stimulus: RESET for 3 cycles, then a pause_btn rising edge.
  - Required: cnt_clr=1 for 3 cycles, state_o=00, then 01 with a single div_sync pulse.
  - Then 5 tick_1hz pulses → exactly 5 cnt_en, each one cycle after its tick.
- **Pause toggle:**
  - Stimulus: in RUN, a pause edge coincident with tick_1hz.
  - Required: state_o=00, no cnt_en.
  - Stimulus: pause_btn held high 10 cycles.
  - Required: only one toggle.
- **Adjust seconds:**
  - Stimulus: adj=1, sel=1, then 4 tick_2hz and 2 tick_1hz.
  - Required: 4 sec_inc, 0 cnt_en, 0 min_inc.
  - Required: blank_sec follows blink_ph toggling on tick_blink; blank_min=0.
- **Sel switch in ADJ:**
  - Stimulus: sel 1→0 with blink_ph=1.
  - Required: blank_sec=0 and blank_min=0 next cycle.
  - Then tick_2hz → min_inc.
- **Exit ADJ:**
  - Entered from RUN: on adj=0 → state_o=01 plus a div_sync pulse.
  - Entered from PAUSED: on adj=0 → state_o=00, no div_sync.
  - A pause edge during ADJ has no effect on the return state.
- **Reset mid-operation:**
  - Stimulus: RESET for 1 cycle while in ADJ with blank_sec=1, pause_btn held high.
  - Required: state_o=00, blanks 0, cnt_clr and div_sync pulse for 1 cycle, no toggle afterwards.
